// File: rtl/matrix_mul_seq_if.sv
// Start/done bus for the sequential matrix multiplier.
// Operands and result use row-major packing with (0,0) in the MSBs.
interface matrix_mul_seq_if #(
  parameter int N  = 3,
  parameter int DW = 8,
  parameter int RW = 16
) ();
  logic                start;
  logic [N*N*DW-1:0]   matrix_a;
  logic [N*N*DW-1:0]   matrix_b;
  logic [N*N*RW-1:0]   result;
  logic                done;
  logic                busy;

  modport master (
    output start, matrix_a, matrix_b,
    input  result, done, busy
  );

  modport slave (
    input  start, matrix_a, matrix_b,
    output result, done, busy
  );
endinterface

// File: rtl/matrix_mul_seq.sv
// N x N matrix multiplier, one MAC per cycle, held result register.
// Define SIGNED_MODE_EN for two's-complement operands and arithmetic.
module matrix_mul_seq #(
  parameter int N  = 3,
  parameter int DW = 8,
  parameter int RW = 16
) (
  input  logic         clk,
  input  logic         reset,
  matrix_mul_seq_if.slave bus
);
  localparam int NN = N * N;
  localparam int CW = $clog2(N);
  localparam int PW = 2 * DW;
  localparam int AW = 2 * DW + $clog2(N);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_e;

  state_e            state_q, state_d;
  logic [NN*DW-1:0]  a_q, a_d;
  logic [NN*DW-1:0]  b_q, b_d;
  logic [CW-1:0]     i_q, i_d;
  logic [CW-1:0]     j_q, j_d;
  logic [CW-1:0]     k_q, k_d;
  logic [AW-1:0]     acc_q, acc_d;
  logic [NN*RW-1:0]  scr_q, scr_d;
  logic [NN*RW-1:0]  res_q, res_d;

  logic [DW-1:0]     a_el;
  logic [DW-1:0]     b_el;
  logic [PW-1:0]     prod;
  logic [AW-1:0]     prod_x;
  logic [AW-1:0]     sum;
  logic [RW-1:0]     elem;
  logic              k_end;
  logic              j_end;
  logic              i_end;

  always_comb begin
    a_el = a_q[(NN-1-(int'(i_q)*N+int'(k_q)))*DW +: DW];
    b_el = b_q[(NN-1-(int'(k_q)*N+int'(j_q)))*DW +: DW];
`ifdef SIGNED_MODE_EN
    prod   = PW'($signed(a_el)) * PW'($signed(b_el));
    prod_x = {{(AW-PW){prod[PW-1]}}, prod};
    sum    = acc_q + prod_x;
    elem   = RW'($signed(sum));
`else
    prod   = PW'(a_el) * PW'(b_el);
    prod_x = {{(AW-PW){1'b0}}, prod};
    sum    = acc_q + prod_x;
    elem   = RW'(sum);
`endif
    k_end = (k_q == CW'(N-1));
    j_end = (j_q == CW'(N-1));
    i_end = (i_q == CW'(N-1));
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    acc_d   = acc_q;
    scr_d   = scr_q;
    res_d   = res_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = CALC;
          a_d     = bus.matrix_a;
          b_d     = bus.matrix_b;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
          acc_d   = '0;
        end
      end
      CALC: begin
        if (k_end) begin
          acc_d = '0;
          k_d   = '0;
          scr_d[(NN-1-(int'(i_q)*N+int'(j_q)))*RW +: RW] = elem;
          if (j_end) begin
            j_d = '0;
            if (i_end) begin
              // last element: publish the whole array atomically
              i_d     = '0;
              state_d = DONE;
              res_d   = scr_d;
            end else begin
              i_d = i_q + 1'b1;
            end
          end else begin
            j_d = j_q + 1'b1;
          end
        end else begin
          acc_d = sum;
          k_d   = k_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      acc_q   <= '0;
      scr_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
      scr_q   <= scr_d;
      res_q   <= res_d;
    end
  end

  assign bus.result = res_q;
  assign bus.done   = (state_q == DONE);
  assign bus.busy   = (state_q != IDLE);

endmodule

// File: doc/matrix_mul_seq.md
# matrix_mul_seq

Parametrised N×N matrix multiplier computing C = A × B with a single time-shared multiply-accumulate unit and a start/done handshake. It replaces the fixed 3×3, 8-bit multiplier in the matrix datapath: element width, matrix size and result width are parameters. Signed arithmetic is a compile-time option. The result is presented in a held output register that updates atomically on completion.

## Interface
- N, 3: matrix dimension (N ≥ 2)
- DW, 8: operand element width in bits
- RW, 16: result element width in bits; the result is the accumulator truncated to its RW LSBs
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request a multiply; sampled only in IDLE
- matrix_a  input  N*N*DW  operand A, row-major; element (r,c) at bits [(N*N-1-(r*N+c))*DW +: DW], so (0,0) is in the MSBs
- matrix_b  input  N*N*DW  operand B, same packing as matrix_a
- result  output  N*N*RW  product C, same packing with RW-bit elements; reset value 0
- done  output  1  one-cycle completion pulse; reset value 0
- busy  output  1  high whenever state ≠ IDLE; reset value 0

## Operation
- States:
  - IDLE → CALC on start=1. The capturing edge latches matrix_a and matrix_b into internal registers and clears i, j, k and the accumulator.
  - CALC → DONE after the final MAC.
  - DONE → IDLE unconditionally after one cycle.
- CALC performs one MAC per cycle: acc ← acc + A[i][k]·B[k][j].
  - Loop order: k innermost, then j, then i.
  - When k = N-1, acc + product is written to scratch element (i,j), acc clears, and j/i advance.
- Accumulator width is 2·DW + clog2(N) bits, so no internal overflow occurs. The output element is acc[RW-1:0]; any higher bits wrap (modulo 2^RW).
- Writes go to internal scratch storage. At the edge that writes element (N-1,N-1), the full scratch array (including that element) is copied to result. Between completions, result holds the previous product.
- Inputs matrix_a and matrix_b may change freely after the start edge; only the latched copies are used.
- start is ignored in CALC and DONE. It is not queued; a start held high is accepted again in the first IDLE cycle.
- Reset at any time, including mid-CALC, has the following effect at the next edge:
  - state → IDLE
  - result, done, busy, counters and accumulator → 0
  - no done pulse is produced for the aborted operation

## Timing
- Edge E0 samples start=1 in IDLE. busy is high from E0.
- Edges E1…E(N³) each perform one MAC.
- At E(N³), result updates and done rises. done falls at E(N³+1).
- busy falls at E(N³+1), giving IDLE in the following cycle. The earliest next start is accepted at E(N³+2).
- Default N=3: result and done are visible 27 cycles after E0. Issue-to-issue interval is 29 cycles.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- SIGNED_MODE_EN defined:
  - operands are two's-complement
  - products and accumulator are signed, with sign extension to full accumulator width
  - result elements are the two's-complement RW LSBs
- SIGNED_MODE_EN undefined: all operands and arithmetic are unsigned. This is the default build.
- Handshake, timing and packing are identical in both builds.

## Test plan
- Unsigned, defaults:
  - A = {1,2,3,4,5,6,7,8,9}, B = {9,8,7,6,5,4,3,2,1}, start for 1 cycle.
  - Expect result = {30,24,18,84,69,54,138,114,90}.
  - Expect done pulse exactly 27 cycles after the start edge, busy high for 28 cycles.
- Identity and scale:
  - A = I, B = {1..9} → result = {1..9}.
  - Then A = 2I → result = {2,4,6,8,10,12,14,16,18}.
  - result holds {1..9} throughout the second CALC.
- start held high continuously across two operations:
  - exactly one done per operation
  - second operation starts at E(N³+2)
  - A/B changes during CALC have no effect on the result
- Reset mid-operation:
  - assert reset at CALC cycle 10 → result = 0, busy = 0, no done.
  - After reset release, a new start with example 1 yields correct values after 27 cycles.
- Overflow, unsigned build: all elements 255 → every result element = 195075 mod 65536 = 64003.
- Signed build (SIGNED_MODE_EN):
  - A and B all 8'hFF (-1) → every element = 3.
  - A = -I, B = {1..9} → result = {-1..-9} as 16-bit two's complement (16'hFFFF … 16'hFFF7).
